// File: rtl/sky130_gpio_pkg.sv
// Shared types for the sky130 GPIO pad controller: channel modes, sequencer
// states, pad drive-mode codes and the mode-to-pad-pin decode.
package sky130_gpio_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        INPUT     = 2'd1,
        PUSHPULL  = 2'd2,
        OPENDRAIN = 2'd3
    } gpio_mode_e;

    typedef enum logic [2:0] {
        RESET   = 3'd0,
        ENABLE  = 3'd1,
        RUN     = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } seq_state_e;

    localparam logic [2:0] DM_OFF    = 3'b000;
    localparam logic [2:0] DM_INPUT  = 3'b001;
    localparam logic [2:0] DM_STRONG = 3'b110;

    typedef struct packed {
        logic       out;
        logic       oe_n;
        logic [2:0] dm;
        logic       inp_dis;
    } pad_ctrl_t;

    // Open-drain drives low by enabling the driver with OUT=0; a 1 releases the pin.
    function automatic pad_ctrl_t pad_decode(input gpio_mode_e mode, input logic data);
        pad_ctrl_t p;
        p = '{out: 1'b0, oe_n: 1'b1, dm: DM_OFF, inp_dis: 1'b1};
        case (mode)
            INPUT: begin
                p.dm      = DM_INPUT;
                p.inp_dis = 1'b0;
            end
            PUSHPULL: begin
                p.dm      = DM_STRONG;
                p.inp_dis = 1'b0;
                p.oe_n    = 1'b0;
                p.out     = data;
            end
            OPENDRAIN: begin
                p.dm      = DM_STRONG;
                p.inp_dis = 1'b0;
                p.oe_n    = data;
            end
            default: ;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sky130_gpio_in_filter.sv
// Per-channel pad input conditioning: two-flop synchroniser, debounce counter
// and single-cycle rise/fall pulses derived from the filtered level.
module sky130_gpio_in_filter #(
    parameter int DEBOUNCE = 4,
    localparam int DB_W = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic pad_in,
    output logic filt,
    output logic rise,
    output logic fall
);

    logic            sync_p0, sync_p1;
    logic            filt_q, filt_d_q;
    logic [DB_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            filt_q   <= 1'b0;
            filt_d_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_p0  <= pad_in;
            sync_p1  <= sync_p0;
            filt_d_q <= filt_q;
            // Disabled channels keep their last level and never count.
            if (!en || (sync_p1 == filt_q)) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_W'(DEBOUNCE)) begin
                filt_q <= sync_p1;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + DB_W'(1);
            end
        end
    end

    assign filt = filt_q;
    assign rise = en &  filt_q & ~filt_d_q;
    assign fall = en & ~filt_q &  filt_d_q;

endmodule

// File: rtl/sky130_gpio_pad_ctrl.sv
// Controller for N sky130 gpiov2 pads: power-up/hold sequencer, per-channel
// mode registers, registered pad-pin decode, input filtering and edge IRQs.
module sky130_gpio_pad_ctrl
    import sky130_gpio_pkg::*;
#(
    parameter int N_CH     = 8,
    parameter int ENA_DLY  = 16,
    parameter int HLD_DLY  = 8,
    parameter int DEBOUNCE = 4,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CFG_VALID,
    output logic              CFG_READY,
    input  logic [CH_W-1:0]   CFG_CH,
    input  logic [1:0]        CFG_MODE,
    input  logic [1:0]        CFG_IRQ_EN,
    input  logic [N_CH-1:0]   OUT_DATA,
    input  logic              HOLD_REQ,
    output logic [N_CH-1:0]   PAD_OUT,
    output logic [N_CH-1:0]   PAD_OE_N,
    output logic [3*N_CH-1:0] PAD_DM,
    output logic [N_CH-1:0]   PAD_INP_DIS,
    output logic              PAD_ENABLE_H,
    output logic              PAD_HLD_H_N,
    input  logic [N_CH-1:0]   PAD_IN,
    output logic [N_CH-1:0]   IN_FILT,
    output logic [N_CH-1:0]   IRQ_STATUS,
    input  logic [N_CH-1:0]   IRQ_CLR,
    output logic              IRQ,
    output logic              READY
);

    localparam int DLY_MAX = (ENA_DLY > HLD_DLY) ? ENA_DLY : HLD_DLY;
    localparam int CNT_W   = $clog2(DLY_MAX + 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] dly_cnt_q, dly_cnt_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= RESET;
            dly_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            dly_cnt_q <= dly_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dly_cnt_d = dly_cnt_q;
        case (state_q)
            RESET: begin
                if (dly_cnt_q == CNT_W'(ENA_DLY - 1)) begin
                    state_d   = ENABLE;
                    dly_cnt_d = '0;
                end else begin
                    dly_cnt_d = dly_cnt_q + CNT_W'(1);
                end
            end
            ENABLE: begin
                if (dly_cnt_q == CNT_W'(HLD_DLY - 1)) begin
                    state_d   = RUN;
                    dly_cnt_d = '0;
                end else begin
                    dly_cnt_d = dly_cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (HOLD_REQ) state_d = HOLD;
            end
            HOLD: begin
                if (!HOLD_REQ) begin
                    state_d   = RELEASE;
                    dly_cnt_d = '0;
                end
            end
            RELEASE: begin
                // A renewed hold request abandons the release and restarts it later.
                if (HOLD_REQ) begin
                    state_d   = HOLD;
                    dly_cnt_d = '0;
                end else if (dly_cnt_q == CNT_W'(HLD_DLY - 1)) begin
                    state_d   = RUN;
                    dly_cnt_d = '0;
                end else begin
                    dly_cnt_d = dly_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = RESET;
                dly_cnt_d = '0;
            end
        endcase
    end

    assign PAD_ENABLE_H = (state_q != RESET);
    assign PAD_HLD_H_N  = (state_q == RUN);
    assign READY        = (state_q == RUN);
    assign CFG_READY    = (state_q == RUN) || (state_q == HOLD);

    // Config register file
    gpio_mode_e            mode_q [N_CH];
    logic [N_CH-1:0][1:0]  irq_en_q;
    logic                  cfg_fire;

    assign cfg_fire = CFG_VALID && CFG_READY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_CH; i++) begin
                mode_q[i]   <= OFF;
                irq_en_q[i] <= 2'b00;
            end
        end else if (cfg_fire && (int'(CFG_CH) < N_CH)) begin
            mode_q[CFG_CH]   <= gpio_mode_e'(CFG_MODE);
            irq_en_q[CFG_CH] <= CFG_IRQ_EN;
        end
    end

    // Pad pin decode, registered and only updated while running
    pad_ctrl_t dec [N_CH];

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            dec[i] = pad_decode(mode_q[i], OUT_DATA[i]);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PAD_OUT     <= '0;
            PAD_OE_N    <= '1;
            PAD_DM      <= '0;
            PAD_INP_DIS <= '1;
        end else if (state_q == RUN) begin
            for (int i = 0; i < N_CH; i++) begin
                PAD_OUT[i]       <= dec[i].out;
                PAD_OE_N[i]      <= dec[i].oe_n;
                PAD_DM[3*i +: 3] <= dec[i].dm;
                PAD_INP_DIS[i]   <= dec[i].inp_dis;
            end
        end
    end

    // Input filters and edge interrupts
    logic [N_CH-1:0] rise, fall, irq_set;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        sky130_gpio_in_filter #(
            .DEBOUNCE (DEBOUNCE)
        ) u_filt (
            .clk    (CLK),
            .rst    (RST),
            .en     (mode_q[g] != OFF),
            .pad_in (PAD_IN[g]),
            .filt   (IN_FILT[g]),
            .rise   (rise[g]),
            .fall   (fall[g])
        );
        assign irq_set[g] = (rise[g] & irq_en_q[g][1]) | (fall[g] & irq_en_q[g][0]);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            IRQ_STATUS <= '0;
            IRQ        <= 1'b0;
        end else begin
            IRQ_STATUS <= irq_set | (IRQ_STATUS & ~IRQ_CLR);
            IRQ        <= |IRQ_STATUS;
        end
    end

endmodule
